// File: rtl/param_multifunction_shift_sequencer.sv
// General-purpose shift/rotate working register with a multi-step "shift by N" sequencer.
// Define SHIFTREG_ABORT_EN to add an abort input that cancels a running sequence.
module param_multifunction_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             e,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
`ifdef SHIFTREG_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_LSL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic [2:0]       execOp;
  logic [WIDTH-1:0] stepQ;
  logic             stepSout;
  logic             isShift;
  logic             abortHit;

  // A running sequence replays the latched op; otherwise the live op is used.
  assign execOp  = busy_q ? op_q : op;
  assign isShift = (op >= OP_LSR) && (op <= OP_ROL);

`ifdef SHIFTREG_ABORT_EN
  assign abortHit = abort & busy_q;
`else
  assign abortHit = 1'b0;
`endif

  always_comb begin
    stepQ    = q_q;
    stepSout = sout_q;
    case (execOp)
      OP_HOLD: ;
      OP_LOAD: stepQ = d;
      OP_LSR:  begin stepQ = {sin, q_q[WIDTH-1:1]};          stepSout = q_q[0];       end
      OP_ASR:  begin stepQ = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; stepSout = q_q[0];       end
      OP_LSL:  begin stepQ = {q_q[WIDTH-2:0], sin};          stepSout = q_q[WIDTH-1]; end
      OP_ROR:  begin stepQ = {q_q[0], q_q[WIDTH-1:1]};       stepSout = q_q[0];       end
      OP_ROL:  begin stepQ = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; stepSout = q_q[WIDTH-1]; end
      OP_CLR:  begin stepQ = '0;                             stepSout = 1'b0;         end
      default: ;
    endcase
  end

  // done is a one-cycle pulse, so it defaults low every edge regardless of e.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (abortHit) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (e) begin
        q_d    = stepQ;
        sout_d = stepSout;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end else if (e) begin
      q_d    = stepQ;
      sout_d = stepSout;
      if (start) begin
        if (isShift && (amt != '0)) begin
          op_d  = op;
          cnt_d = amt - AMT_W'(1);
          if (amt == AMT_W'(1)) done_d = 1'b1;
          else                  busy_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_HOLD;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_param_multifunction_shift_sequencer.sv
// Directed self-checking bench for param_multifunction_shift_sequencer (WIDTH=8, AMT_W=4).
module tb_param_multifunction_shift_sequencer;

  logic       clock;
  logic       reset;
  logic       e;
  logic [2:0] op;
  logic       start;
  logic [3:0] amt;
  logic       sin;
  logic [7:0] d;
`ifdef SHIFTREG_ABORT_EN
  logic       abort;
`endif
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  param_multifunction_shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .e     (e),
    .op    (op),
    .start (start),
    .amt   (amt),
    .sin   (sin),
    .d     (d),
`ifdef SHIFTREG_ABORT_EN
    .abort (abort),
`endif
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it; inputs change here too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadValue(input logic [7:0] v);
    op = 3'b001; d = v; start = 1'b0; e = 1'b1;
    tick();
    op = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    loadValue(8'hFF);
    checks++; if (q !== 8'hFF) begin errors++; $display("[TB] FAIL reset_preload: q=%h expected ff", q); end
    #2 reset = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_async_q: q=%h expected 00", q); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_async_flags: busy=%b done=%b sout=%b expected 0 0 0", busy, done, sout); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_step();
    loadValue(8'hAA);
    op = 3'b011;
    tick();
    op = 3'b000;
    checks++; if (q !== 8'hD5 || sout !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL single_asr: q=%h sout=%b done=%b expected d5 0 0", q, sout, done); end
  endtask

  task automatic test_lsr_seq();
    loadValue(8'hAA);
    op = 3'b010; amt = 4'd3; sin = 1'b0; start = 1'b1;
    tick();
    checks++; if (q !== 8'h55 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL lsr_step1: q=%h busy=%b done=%b expected 55 1 0", q, busy, done); end
    start = 1'b0; op = 3'b001; d = 8'hFF; amt = 4'd0;
    tick();
    checks++; if (q !== 8'h2A || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL lsr_step2: q=%h busy=%b done=%b expected 2a 1 0", q, busy, done); end
    tick();
    op = 3'b000;
    checks++; if (q !== 8'h15 || busy !== 1'b0 || done !== 1'b1 || sout !== 1'b0) begin
      errors++; $display("[TB] FAIL lsr_final: q=%h busy=%b done=%b sout=%b expected 15 0 1 0", q, busy, done, sout); end
    tick();
    checks++; if (done !== 1'b0 || q !== 8'h15) begin
      errors++; $display("[TB] FAIL lsr_done_clear: q=%h done=%b expected 15 0", q, done); end
  endtask

  task automatic test_rol_wrap();
    int busyCycles = 0;
    int doneCount = 0;
    loadValue(8'h81);
    op = 3'b110; amt = 4'd10; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    busyCycles += (busy === 1'b1) ? 1 : 0;
    doneCount  += (done === 1'b1) ? 1 : 0;
    for (int k = 2; k <= 10; k++) begin
      tick();
      busyCycles += (busy === 1'b1) ? 1 : 0;
      doneCount  += (done === 1'b1) ? 1 : 0;
    end
    checks++; if (q !== 8'h06 || sout !== 1'b0 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL rol10_final: q=%h sout=%b done=%b expected 06 0 1", q, sout, done); end
    tick();
    doneCount += (done === 1'b1) ? 1 : 0;
    checks++; if (busyCycles != 9) begin
      errors++; $display("[TB] FAIL rol10_busy_cycles: got %0d expected 9", busyCycles); end
    checks++; if (doneCount != 1) begin
      errors++; $display("[TB] FAIL rol10_done_pulses: got %0d expected 1", doneCount); end
  endtask

  task automatic test_ror_stall();
    loadValue(8'h0F);
    op = 3'b101; amt = 4'd4; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    tick();
    checks++; if (q !== 8'hC3 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL ror_step2: q=%h busy=%b expected c3 1", q, busy); end
    e = 1'b0;
    tick(); tick();
    checks++; if (q !== 8'hC3 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL ror_stall: q=%h busy=%b done=%b expected c3 1 0", q, busy, done); end
    e = 1'b1;
    tick();
    checks++; if (q !== 8'hE1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL ror_step3: q=%h busy=%b done=%b expected e1 1 0", q, busy, done); end
    tick();
    checks++; if (q !== 8'hF0 || busy !== 1'b0 || done !== 1'b1 || sout !== 1'b1) begin
      errors++; $display("[TB] FAIL ror_final: q=%h busy=%b done=%b sout=%b expected f0 0 1 1", q, busy, done, sout); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL ror_done_clear: done=%b expected 0", done); end
  endtask

  task automatic test_reset_mid_seq();
    loadValue(8'hAA);
    op = 3'b010; amt = 4'd7; sin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    tick(); tick();
    checks++; if (q !== 8'h15 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_pre: q=%h busy=%b expected 15 1", q, busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_abort: q=%h busy=%b done=%b sout=%b expected 00 0 0 0", q, busy, done, sout); end
    #1 reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_no_done: busy=%b done=%b expected 0 0", busy, done); end
    loadValue(8'h3C);
    op = 3'b000; amt = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL amt0_done: q=%h done=%b busy=%b expected 3c 1 0", q, done, busy); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL amt0_clear: done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_amt_one();
    loadValue(8'h81);
    op = 3'b100; sin = 1'b1; amt = 4'd1; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000; sin = 1'b0;
    checks++; if (q !== 8'h03 || sout !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL lsl_amt1: q=%h sout=%b busy=%b done=%b expected 03 1 0 1", q, sout, busy, done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL lsl_amt1_clear: done=%b expected 0", done); end
  endtask

  task automatic test_saturate();
    loadValue(8'h80);
    op = 3'b011; amt = 4'd9; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    for (int k = 2; k <= 9; k++) tick();
    checks++; if (q !== 8'hFF || sout !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL asr9_sat: q=%h sout=%b done=%b busy=%b expected ff 1 1 0", q, sout, done, busy); end
    tick();
  endtask

  task automatic test_clear_start();
    loadValue(8'h5A);
    op = 3'b111; amt = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b000;
    checks++; if (q !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL clr_start: q=%h sout=%b busy=%b done=%b expected 00 0 0 1", q, sout, busy, done); end
    tick();
  endtask

  initial begin
    reset = 1'b0; e = 1'b1; op = 3'b000; start = 1'b0; amt = 4'd0; sin = 1'b0; d = 8'h00;
`ifdef SHIFTREG_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_single_step();
    test_lsr_seq();
    test_rol_wrap();
    test_ror_stall();
    test_reset_mid_seq();
    test_amt_one();
    test_saturate();
    test_clear_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_multifunction_shift_sequencer.md
Name: param_multifunction_shift_sequencer

Overview:
Parametrised successor to the 8-bit multifunction register, with generic width and a wider operation set: load, clear, logical/arithmetic right shift, left shift and both rotates. It adds a multi-cycle "shift by N" sequencer with a start/busy/done handshake, so the datapath can request shifts of arbitrary length without re-issuing single-step commands. It sits in the datapath as a general-purpose working register.

Parameters:
WIDTH, 8, register and data width in bits (min 2)
AMT_W, 4, width of shift-amount input; amounts 0..2^AMT_W-1 accepted

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
e  input  1  enable; 0 = freeze all state except done clear
op  input  3  operation select (see Behaviour)
start  input  1  request multi-step sequence of op, length amt
amt  input  AMT_W  number of steps for sequence
sin  input  1  serial in for LSR/LSL
d  input  WIDTH  parallel load data
q  output  WIDTH  register contents
sout  output  1  registered last bit shifted/rotated out
busy  output  1  sequence in progress
done  output  1  one-cycle pulse after sequence completes

Behaviour:
- Reset is asynchronous and active-low: q=0, sout=0, busy=0, done=0, step counter=0, latched op=000; held while reset=0.
- Op encoding:
  - 000 hold
  - 001 load d
  - 010 LSR (sin into MSB)
  - 011 ASR (MSB replicated)
  - 100 LSL (sin into LSB)
  - 101 ROR
  - 110 ROL
  - 111 sync clear (q=0, sout=0)
- sout captures the bit leaving: q[0] for right ops, q[WIDTH-1] for left ops. Unchanged by hold/load.
- Idle, start=0, e=1: op applied once per edge (single-step mode); done stays 0.
- Idle, start=1, e=1, shift/rotate op, amt>=1:
  - the first step executes at the same edge; op is latched, counter=amt-1.
  - busy=1 from that edge while counter>0.
  - each further enabled edge executes the latched op and decrements the counter.
  - the edge that performs the final step clears busy and sets done for exactly one cycle.
- Step latency: amt=N completes on the Nth enabled edge; amt=1 never raises busy.
- start with amt=0, or with op 000/001/111: op executes once (000 = no change); done pulses the next cycle; busy never set.
- While busy: op, amt and start are ignored; sin is sampled live each step.
- e=0 while busy: stalls the sequence; q and counter are held; busy stays 1.
- done clears on the next edge regardless of e.
- Amount > WIDTH:
  - LSR/LSL/ASR saturate naturally (all zeros, all sin, or all sign).
  - rotates wrap (amt mod WIDTH net effect), but still take amt cycles.
- Reset mid-sequence aborts immediately to reset values; no done pulse.

Optional Feature:
- SHIFTREG_ABORT_EN defined: adds input port abort (1 bit).
  - abort=1 while busy, at an edge (e ignored): no step is performed, busy=0, counter=0, done stays 0, q/sout hold current values.
  - abort while idle has no effect.
- Undefined: no abort port; a sequence always runs to completion or reset.

Test Plan:
- reset=0 pulse after q loaded with 8'hFF (asynchronous, between edges) -> q=8'h00, busy=0, done=0 immediately, before next edge.
- Load 1010_1010, then single-step op=011 -> q=1101_0101, sout=0, done=0.
- q=1010_1010, start op=010 amt=3 sin=0 -> q=0001_0101 after 3rd edge; busy=1 for 2 cycles; done=1 one cycle; sout=0.
- q=1000_0001, start op=110 amt=10 -> after 10 edges q=0000_0110, sout=0, done single pulse; busy=1 for 9 cycles.
- q=0000_1111, start op=101 amt=4, e=0 for 2 cycles mid-sequence -> q held during stall; final q=1111_0000 on 4th enabled edge; done 1 cycle.
- Reset asserted while busy (LSR amt=7, 3 steps done) -> q=0, busy=0, no done. Then start amt=0 -> q unchanged, done pulses one cycle, busy stays 0.
